// File: rtl/post_prog_loader_if.sv
// Host-side and core-side signal bundle of the program loader.
// The slave modport is the loader's view; the master modport is the driver's view.
interface post_prog_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din;
  logic              wr_strobe;
  logic              load_mode;
  logic              start_req;
  logic              core_done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              core_start;
  logic [ADDR_W:0]   prog_len;
  logic [7:0]        chk;
  logic              overflow;
  logic [1:0]        state;

  modport slave (
    input  din, wr_strobe, load_mode, start_req, core_done,
    output mem_we, mem_addr, mem_wdata, core_start, prog_len, chk, overflow, state
  );

  modport master (
    output din, wr_strobe, load_mode, start_req, core_done,
    input  mem_we, mem_addr, mem_wdata, core_start, prog_len, chk, overflow, state
  );
endinterface

// File: rtl/post_prog_loader.sv
// Program-loading front end: synchronises host strobes, writes program bytes,
// tracks length and XOR checksum, and launches the core once loading is closed.
module post_prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  post_prog_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    RUN   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        wr_sync_q, wr_sync_d;
  logic [2:0]        st_sync_q, st_sync_d;
  logic [2:0]        lm_sync_q, lm_sync_d;
  logic              wr_edge_q, wr_edge_d;
  logic              st_edge_q, st_edge_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              core_start_q, core_start_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic [7:0]        chk_q, chk_d;
  logic              overflow_q, overflow_d;

  always_comb begin
    // Edge registers and the third load_mode flop align all three inputs
    // so that a strobe edge and a load_mode fall land in the same cycle.
    wr_sync_d    = {wr_sync_q[1:0], bus.wr_strobe};
    st_sync_d    = {st_sync_q[1:0], bus.start_req};
    lm_sync_d    = {lm_sync_q[1:0], bus.load_mode};
    wr_edge_d    = wr_sync_q[1] & ~wr_sync_q[2];
    st_edge_d    = st_sync_q[1] & ~st_sync_q[2];

    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_start_d = core_start_q;
    prog_len_d   = prog_len_q;
    chk_d        = chk_q;
    overflow_d   = overflow_q;

    if (ena) begin
      mem_we_d     = 1'b0;
      core_start_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (lm_sync_q[2]) begin
            state_d    = LOAD;
            prog_len_d = '0;
            chk_d      = '0;
            overflow_d = 1'b0;
          end
        end
        LOAD: begin
          if (wr_edge_q) begin
            // prog_len never exceeds DEPTH, so its MSB set means "full"
            if (!prog_len_q[ADDR_W]) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = prog_len_q[ADDR_W-1:0];
              mem_wdata_d = bus.din;
              prog_len_d  = prog_len_q + (ADDR_W+1)'(1);
              chk_d       = chk_q ^ 8'(bus.din);
            end else begin
              overflow_d  = 1'b1;
            end
          end
          if (!lm_sync_q[2]) begin
            state_d = (prog_len_d != '0) ? READY : IDLE;
          end
        end
        READY: begin
          if (lm_sync_q[2]) begin
            state_d    = LOAD;
            prog_len_d = '0;
            chk_d      = '0;
            overflow_d = 1'b0;
          end else if (st_edge_q) begin
            state_d      = RUN;
            core_start_d = 1'b1;
          end
        end
        RUN: begin
          if (bus.core_done) begin
            state_d = READY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_sync_q    <= '0;
      st_sync_q    <= '0;
      lm_sync_q    <= '0;
      wr_edge_q    <= 1'b0;
      st_edge_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_start_q <= 1'b0;
      prog_len_q   <= '0;
      chk_q        <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_sync_q    <= wr_sync_d;
      st_sync_q    <= st_sync_d;
      lm_sync_q    <= lm_sync_d;
      wr_edge_q    <= wr_edge_d;
      st_edge_q    <= st_edge_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_start_q <= core_start_d;
      prog_len_q   <= prog_len_d;
      chk_q        <= chk_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.core_start = core_start_q;
  assign bus.prog_len   = prog_len_q;
  assign bus.chk        = chk_q;
  assign bus.overflow   = overflow_q;
  assign bus.state      = state_q;

endmodule
